uart_rx_fsm_ctrl: RTL and testbench
===================================

// Module: uart_rx_fsm_ctrl
// PURPOSE
//  Frame sequencer for the UART receiver. Detects the start edge and runs the
//  oversampling edge counter and the frame bit counter. Drives the sampler
//  enable and the start/data/parity/stop check strobes, and issues data_valid.
//  It sits between RX_IN, the sampler, the deserializer and the three checkers.
// PARAMETERS
//  PRESCALE_W  6  width of prescale and edge_count (prescale 4..2**PRESCALE_W-1)
//  DATA_W      8  data bits per frame, LSB first
//  BITCNT_W    4  width of bit_count; must hold DATA_W+2
// PORTS
//  clk           in   1            receiver clock (oversampling rate)
//  rst           in   1            async reset, active-high
//  RX_IN         in   1            serial line, idles high
//  prescale      in   PRESCALE_W   oversampling ratio per bit, even, >=4
//  PAR_EN        in   1            1 = frame carries a parity bit
//  strt_glitch   in   1            start checker result, valid with strt_chk_en
//  par_err       in   1            parity checker result, valid with par_chk_en
//  stp_err       in   1            stop checker result, valid with stp_chk_en
//  edge_count    out  PRESCALE_W   oversample index within current bit
//  bit_count     out  BITCNT_W     frame position: 0 = start, 1..DATA_W = data, then parity, stop
//  data_sample_en out 1            sampler enable
//  deser_en      out  1            1-cycle shift strobe to the deserializer
//  strt_chk_en   out  1            1-cycle strobe to the start checker
//  par_chk_en    out  1            1-cycle strobe to the parity checker
//  stp_chk_en    out  1            1-cycle strobe to the stop checker
//  data_valid    out  1            1-cycle pulse: frame accepted, error-free
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; latched prescale and error flags 0. Reset
//    mid-frame aborts the frame immediately and raises no data_valid.
//  - States: IDLE, START, DATA, PARITY, STOP, DONE (registered, one-hot or binary).
//  - Define last_edge = (edge_count == pre_q-1), where pre_q is prescale latched
//    on leaving IDLE. A prescale change mid-frame takes effect on the next frame.
//  - edge_count: 0 in IDLE. It increments every cycle outside IDLE/DONE and wraps
//    to 0 on last_edge. Its first value in START is 0.
//  - data_sample_en: 1 in START/DATA/PARITY/STOP, 0 in IDLE/DONE.
//  - IDLE -> START when RX_IN==0 (sampled on the clk edge); bit_count=0.
//  - START: strt_chk_en=1 on last_edge. If strt_glitch=1 in that cycle, go to
//    IDLE with no strobe to the other checkers. Otherwise go to DATA with bit_count=1.
//  - DATA: deser_en=1 on each last_edge. bit_count increments on each last_edge.
//    After bit DATA_W: go to PARITY if PAR_EN, else STOP.
//  - PARITY: par_chk_en=1 on last_edge; par_err is ORed into err_q; go to STOP.
//  - STOP: stp_chk_en=1 on last_edge; stp_err is ORed into err_q; go to DONE.
//  - DONE (1 cycle): data_valid=1 iff err_q==0. Then err_q, bit_count and
//    edge_count clear and the block goes to IDLE. If RX_IN==0 in the DONE cycle,
//    go directly to START for back-to-back frames.
//  - PAR_EN is sampled on leaving IDLE and held for the frame.
//  - Strobes are mutually exclusive, combinational from state and counters, and
//    never high in IDLE/DONE.
//  - Frame length in data_sample_en cycles = pre_q*(DATA_W+2+PAR_EN).
// CONFIGURATION
//  UART_RX_ERR_FLAGS_EN defined: adds outputs par_error and framing_error (1 bit
//    each). They are registered, updated in DONE from the per-frame latched
//    flags, held until the next DONE, and cleared by rst.
//  Not defined: ports are absent; errors only suppress data_valid.
// TESTING
//  1 prescale=8, PAR_EN=0, frame 0xA5 with stop=1 -> deser_en pulses 8x at
//    edge 7; data_valid 1 cycle; 80 enabled cycles.
//  2 prescale=8, PAR_EN=1, par_err forced 1 at par_chk_en -> no data_valid;
//    par_error=1 with UART_RX_ERR_FLAGS_EN.
//  3 RX_IN low for 2 cycles only, strt_glitch=1 at edge 7 -> returns to IDLE;
//    no deser_en; bit_count=0.
//  4 stop bit 0, stp_err=1 -> no data_valid; framing_error=1 with macro; next
//    frame 0x3C accepted cleanly.
//  5 two back-to-back frames, RX_IN low in DONE -> second START begins next
//    cycle; two data_valid pulses 81 cycles apart (prescale=8, no parity).
//  6 rst asserted at DATA bit 4, edge 3 -> all outputs 0 asynchronously; after
//    release, idle line -> stays IDLE.

Source files
------------

// File: rtl/uart_rx_fsm_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm_ctrl_if
//   Bundles the signals between the UART receive frame sequencer and its
//   neighbours (serial line, sampler, deserializer, start/parity/stop
//   checkers).
//
//   master modport : the sequencer (uart_rx_fsm_ctrl)
//   slave  modport : the surrounding receiver datapath / test environment
//
//   Signals
//     RX_IN          serial line, idles high
//     prescale       oversampling ratio per bit (even, >= 4)
//     PAR_EN         frame carries a parity bit
//     strt_glitch    start checker result, valid with strt_chk_en
//     par_err        parity checker result, valid with par_chk_en
//     stp_err        stop checker result, valid with stp_chk_en
//     edge_count     oversample index within the current bit
//     bit_count      frame position (0 start, 1..DATA_W data, parity, stop)
//     data_sample_en sampler enable
//     deser_en       deserializer shift strobe
//     strt_chk_en    start checker strobe
//     par_chk_en     parity checker strobe
//     stp_chk_en     stop checker strobe
//     data_valid     frame accepted without error
//
//   Optional feature macro: UART_RX_ERR_FLAGS_EN adds par_error and
//   framing_error (registered per-frame error flags).
// ---------------------------------------------------------------------------
interface uart_rx_fsm_ctrl_if #(
  parameter int PRESCALE_W = 6,
  parameter int BITCNT_W   = 4
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] prescale;
  logic                  PAR_EN;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_count;
  logic [BITCNT_W-1:0]   bit_count;
  logic                  data_sample_en;
  logic                  deser_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;

`ifdef UART_RX_ERR_FLAGS_EN
  logic                  par_error;
  logic                  framing_error;

  modport master (
    input  RX_IN, prescale, PAR_EN, strt_glitch, par_err, stp_err,
    output edge_count, bit_count, data_sample_en, deser_en,
           strt_chk_en, par_chk_en, stp_chk_en, data_valid,
           par_error, framing_error
  );

  modport slave (
    output RX_IN, prescale, PAR_EN, strt_glitch, par_err, stp_err,
    input  edge_count, bit_count, data_sample_en, deser_en,
           strt_chk_en, par_chk_en, stp_chk_en, data_valid,
           par_error, framing_error
  );
`else
  modport master (
    input  RX_IN, prescale, PAR_EN, strt_glitch, par_err, stp_err,
    output edge_count, bit_count, data_sample_en, deser_en,
           strt_chk_en, par_chk_en, stp_chk_en, data_valid
  );

  modport slave (
    output RX_IN, prescale, PAR_EN, strt_glitch, par_err, stp_err,
    input  edge_count, bit_count, data_sample_en, deser_en,
           strt_chk_en, par_chk_en, stp_chk_en, data_valid
  );
`endif
endinterface

// File: rtl/uart_rx_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm_ctrl
//   Frame sequencer for the UART receiver. Detects the start edge, runs the
//   oversampling edge counter and the frame bit counter, drives the sampler
//   enable and the start/data/parity/stop check strobes, and issues
//   data_valid for an error-free frame.
//
//   Ports
//     clk  receiver clock (oversampling rate)
//     rst  asynchronous reset, active-high
//     bus  uart_rx_fsm_ctrl_if.master (line, prescale, PAR_EN, checker
//          results in; counters, strobes and data_valid out)
//
//   Optional feature macro: UART_RX_ERR_FLAGS_EN
//     Adds registered par_error / framing_error outputs, updated in DONE from
//     the flags latched during the frame and held until the next DONE.
//     Without it, errors only suppress data_valid.
// ---------------------------------------------------------------------------
module uart_rx_fsm_ctrl #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8,
  parameter int BITCNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_rx_fsm_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [PRESCALE_W-1:0] EDGE_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] EDGE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  localparam logic [BITCNT_W-1:0]   BIT_ZERO  = {BITCNT_W{1'b0}};
  localparam logic [BITCNT_W-1:0]   BIT_ONE   = {{(BITCNT_W-1){1'b0}}, 1'b1};
  localparam logic [BITCNT_W-1:0]   BIT_LAST  = BITCNT_W'(DATA_W);

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BITCNT_W-1:0]   bit_q, bit_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  par_en_q, par_en_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stp_flag_q, stp_flag_d;

  logic                  last_edge_s;
  logic [PRESCALE_W-1:0] edge_adv_s;
  logic                  err_s;
  logic                  sample_en_s;
  logic                  deser_en_s;
  logic                  strt_chk_s;
  logic                  par_chk_s;
  logic                  stp_chk_s;
  logic                  valid_s;

  // Bit boundary uses the prescale captured at frame start, so a change on
  // the prescale input only affects the following frame.
  assign last_edge_s = (edge_q == (pre_q - EDGE_ONE));
  assign edge_adv_s  = last_edge_s ? EDGE_ZERO : (edge_q + EDGE_ONE);
  assign err_s       = par_flag_q | stp_flag_q;

  // State, counters and per-frame latched configuration/error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      edge_q     <= EDGE_ZERO;
      bit_q      <= BIT_ZERO;
      pre_q      <= EDGE_ZERO;
      par_en_q   <= 1'b0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      pre_q      <= pre_d;
      par_en_q   <= par_en_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
    end
  end

  // Next-state, counter update and strobe decode
  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    bit_d       = bit_q;
    pre_d       = pre_q;
    par_en_d    = par_en_q;
    par_flag_d  = par_flag_q;
    stp_flag_d  = stp_flag_q;
    sample_en_s = 1'b0;
    deser_en_s  = 1'b0;
    strt_chk_s  = 1'b0;
    par_chk_s   = 1'b0;
    stp_chk_s   = 1'b0;
    valid_s     = 1'b0;

    case (state_q)
      IDLE: begin
        edge_d = EDGE_ZERO;
        bit_d  = BIT_ZERO;
        if (bus.RX_IN == 1'b0) begin
          state_d    = START;
          pre_d      = bus.prescale;
          par_en_d   = bus.PAR_EN;
          par_flag_d = 1'b0;
          stp_flag_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        sample_en_s = 1'b1;
        edge_d      = edge_adv_s;
        if (last_edge_s) begin
          strt_chk_s = 1'b1;
          // A glitch aborts silently; no other checker sees this frame.
          if (bus.strt_glitch) begin
            state_d = IDLE;
            bit_d   = BIT_ZERO;
          end else begin
            state_d = DATA;
            bit_d   = BIT_ONE;
          end
        end else begin
          state_d = START;
        end
      end

      DATA: begin
        sample_en_s = 1'b1;
        edge_d      = edge_adv_s;
        if (last_edge_s) begin
          deser_en_s = 1'b1;
          bit_d      = bit_q + BIT_ONE;
          if (bit_q == BIT_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end

      PARITY: begin
        sample_en_s = 1'b1;
        edge_d      = edge_adv_s;
        if (last_edge_s) begin
          par_chk_s  = 1'b1;
          par_flag_d = par_flag_q | bus.par_err;
          bit_d      = bit_q + BIT_ONE;
          state_d    = STOP;
        end else begin
          state_d = PARITY;
        end
      end

      STOP: begin
        sample_en_s = 1'b1;
        edge_d      = edge_adv_s;
        if (last_edge_s) begin
          stp_chk_s  = 1'b1;
          stp_flag_d = stp_flag_q | bus.stp_err;
          state_d    = DONE;
        end else begin
          state_d = STOP;
        end
      end

      DONE: begin
        valid_s    = ~err_s;
        edge_d     = EDGE_ZERO;
        bit_d      = BIT_ZERO;
        par_flag_d = 1'b0;
        stp_flag_d = 1'b0;
        // Line already low: treat this cycle as the start detection of a
        // back-to-back frame.
        if (bus.RX_IN == 1'b0) begin
          state_d  = START;
          pre_d    = bus.prescale;
          par_en_d = bus.PAR_EN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        edge_d     = EDGE_ZERO;
        bit_d      = BIT_ZERO;
        par_flag_d = 1'b0;
        stp_flag_d = 1'b0;
      end
    endcase
  end

`ifdef UART_RX_ERR_FLAGS_EN
  logic par_error_q;
  logic framing_error_q;

  // Error flags published once per completed frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_error_q     <= 1'b0;
      framing_error_q <= 1'b0;
    end else if (state_q == DONE) begin
      par_error_q     <= par_flag_q;
      framing_error_q <= stp_flag_q;
    end else begin
      par_error_q     <= par_error_q;
      framing_error_q <= framing_error_q;
    end
  end

  assign bus.par_error     = par_error_q;
  assign bus.framing_error = framing_error_q;
`endif

  assign bus.edge_count     = edge_q;
  assign bus.bit_count      = bit_q;
  assign bus.data_sample_en = sample_en_s;
  assign bus.deser_en       = deser_en_s;
  assign bus.strt_chk_en    = strt_chk_s;
  assign bus.par_chk_en     = par_chk_s;
  assign bus.stp_chk_en     = stp_chk_s;
  assign bus.data_valid     = valid_s;

endmodule

// File: tb/tb_uart_rx_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm_ctrl
//   Directed frames are driven onto RX_IN; for each frame the expected outcome
//   is queued. A monitor on the falling clock edge captures the data bits at
//   deser_en, counts enabled cycles and strobes, and on stp_chk_en (or a
//   start glitch) pops the queued expectation and compares.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm_ctrl;
  localparam int PRESCALE_W = 6;
  localparam int DATA_W     = 8;
  localparam int BITCNT_W   = 4;

  logic clk;
  logic rst;

  uart_rx_fsm_ctrl_if #(.PRESCALE_W(PRESCALE_W), .BITCNT_W(BITCNT_W)) bus ();

  uart_rx_fsm_ctrl #(
    .PRESCALE_W(PRESCALE_W),
    .DATA_W    (DATA_W),
    .BITCNT_W  (BITCNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                kind;      // 0 = full frame, 1 = start glitch
    logic [DATA_W-1:0] data;
    logic              dv;
    logic              perr;
    logic              ferr;
    int                en_cycles;
    int                pre;
    int                gap;       // cycles since previous data_valid, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [DATA_W-1:0] data, input logic dv,
                      input logic perr, input logic ferr, input int en, input int pre,
                      input int gap);
    exp_t e;
    e.kind = kind; e.data = data; e.dv = dv; e.perr = perr; e.ferr = ferr;
    e.en_cycles = en; e.pre = pre; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int                en_cnt = 0;
  int                dcnt = 0;
  int                cyc = 0;
  int                last_dv_cyc = 0;
  int                n_strb;
  logic [DATA_W-1:0] cap = '0;
  exp_t              cur;
  bit                dv_pending = 1'b0;
  bit                flag_pending = 1'b0;
  bit                glitch_pending = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        en_cnt = 0; dcnt = 0; cap = '0;
        dv_pending = 1'b0; flag_pending = 1'b0; glitch_pending = 1'b0;
      end else begin
`ifdef UART_RX_ERR_FLAGS_EN
        if (flag_pending) begin
          check("par_error", {31'd0, bus.par_error}, {31'd0, cur.perr});
          check("framing_error", {31'd0, bus.framing_error}, {31'd0, cur.ferr});
        end
`endif
        flag_pending = 1'b0;
        if (dv_pending || bus.data_valid) begin
          check("data_valid", {31'd0, bus.data_valid}, {31'd0, (dv_pending ? cur.dv : 1'b0)});
          if (dv_pending && bus.data_valid && cur.gap != 0)
            check("dv_gap", cyc - last_dv_cyc, cur.gap);
          if (bus.data_valid) last_dv_cyc = cyc;
          if (dv_pending) flag_pending = 1'b1;
          dv_pending = 1'b0;
        end
        if (glitch_pending) begin
          check("glitch_bit_count", {28'd0, bus.bit_count}, 32'd0);
          check("glitch_sample_en", {31'd0, bus.data_sample_en}, 32'd0);
          glitch_pending = 1'b0;
        end
        if (bus.data_sample_en) en_cnt++;
        n_strb = int'(bus.strt_chk_en) + int'(bus.deser_en) + int'(bus.par_chk_en) +
                 int'(bus.stp_chk_en);
        if (n_strb > 0) check("strobe_onehot", n_strb, 32'd1);
        if (bus.deser_en) begin
          cap = {bus.RX_IN, cap[DATA_W-1:1]};
          dcnt++;
          if (exp_q.size() > 0) check("deser_edge", {26'd0, bus.edge_count}, exp_q[0].pre - 1);
        end
        if (bus.strt_chk_en && bus.strt_glitch) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_glitch_abort: got strobe expected none");
          end else begin
            cur = exp_q.pop_front();
            check("glitch_kind", cur.kind, 32'd1);
            check("glitch_deser_cnt", dcnt, 32'd0);
            glitch_pending = 1'b1;
          end
          en_cnt = 0; dcnt = 0;
        end
        if (bus.stp_chk_en) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_stp_chk_en: got strobe expected none");
          end else begin
            cur = exp_q.pop_front();
            check("frame_kind", cur.kind, 32'd0);
            check("frame_data", {24'd0, cap}, {24'd0, cur.data});
            check("deser_count", dcnt, DATA_W);
            check("enabled_cycles", en_cnt, cur.en_cycles);
            dv_pending = 1'b1;
          end
          en_cnt = 0; dcnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    tick(n);
  endtask

  // Start bit is held pre+1 cycles: one detection cycle plus the START bit.
  task automatic send_frame(input int pre, input logic [DATA_W-1:0] data, input bit par_en,
                            input logic par_bit, input logic stop_bit, input bit perr,
                            input bit serr, input bit chg_cfg);
    bus.prescale    = pre[PRESCALE_W-1:0];
    bus.PAR_EN      = par_en;
    bus.par_err     = perr;
    bus.stp_err     = serr;
    bus.strt_glitch = 1'b0;
    bus.RX_IN       = 1'b0;
    for (int i = 0; i <= pre; i++) begin
      tick(1);
      if (chg_cfg && i == 1) begin
        bus.prescale = 6'd12;
        bus.PAR_EN   = ~par_en;
      end
    end
    for (int b = 0; b < DATA_W; b++) begin
      bus.RX_IN = data[b];
      tick(pre);
    end
    if (par_en) begin
      bus.RX_IN = par_bit;
      tick(pre);
    end
    bus.RX_IN = stop_bit;
    tick(pre);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_edge_count"}, {26'd0, bus.edge_count}, 32'd0);
    check({tag, "_bit_count"}, {28'd0, bus.bit_count}, 32'd0);
    check({tag, "_outputs"}, {26'd0, bus.data_sample_en, bus.deser_en, bus.strt_chk_en,
                              bus.par_chk_en, bus.stp_chk_en, bus.data_valid}, 32'd0);
`ifdef UART_RX_ERR_FLAGS_EN
    check({tag, "_err_flags"}, {30'd0, bus.par_error, bus.framing_error}, 32'd0);
`endif
  endtask

  initial begin
    rst             = 1'b1;
    bus.RX_IN       = 1'b1;
    bus.prescale    = 6'd8;
    bus.PAR_EN      = 1'b0;
    bus.strt_glitch = 1'b0;
    bus.par_err     = 1'b0;
    bus.stp_err     = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    idle(5);

    // 1: clean 0xA5, no parity
    push(0, 8'hA5, 1'b1, 1'b0, 1'b0, 80, 8, 0);
    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);

    // 2: parity frame with parity error
    push(0, 8'h96, 1'b0, 1'b1, 1'b0, 88, 8, 0);
    send_frame(8, 8'h96, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(10);
`ifdef UART_RX_ERR_FLAGS_EN
    check("par_error_held", {31'd0, bus.par_error}, 32'd1);
`endif

    // 6: reset at DATA bit 4, edge 3
    bus.par_err  = 1'b0;
    bus.prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.RX_IN    = 1'b0;
    tick(36);
    check("pre_rst_bit_count", {28'd0, bus.bit_count}, 32'd4);
    check("pre_rst_edge_count", {26'd0, bus.edge_count}, 32'd3);
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    tick(2);
    rst = 1'b0;
    idle(20);
    check_all_zero("post_rst_idle");

    // 3: start glitch
    push(1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8, 0);
    bus.strt_glitch = 1'b1;
    bus.RX_IN       = 1'b0;
    tick(2);
    bus.RX_IN = 1'b1;
    tick(12);
    bus.strt_glitch = 1'b0;
    idle(5);

    // 4: framing error, then clean 0x3C
    push(0, 8'hF0, 1'b0, 1'b0, 1'b1, 80, 8, 0);
    send_frame(8, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    push(0, 8'h3C, 1'b1, 1'b0, 1'b0, 80, 8, 0);
    send_frame(8, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);

    // 5: back-to-back frames
    push(0, 8'h55, 1'b1, 1'b0, 1'b0, 80, 8, 0);
    push(0, 8'hC3, 1'b1, 1'b0, 1'b0, 80, 8, 81);
    send_frame(8, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);

    // minimum prescale; prescale and PAR_EN change mid-frame
    push(0, 8'h5A, 1'b1, 1'b0, 1'b0, 40, 4, 0);
    send_frame(4, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(10);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
